qc_ldpc_stream_encoder: RTL

QC_LDPC_STREAM_ENCODER -- requirements
Module: qc_ldpc_stream_encoder

---
 rtl/qc_ldpc_stream_encoder.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/qc_ldpc_stream_encoder.sv
// Streaming QC-LDPC parity encoder: accumulates rotated info blocks per parity row, then drains MB parity blocks.
// Optional macro QC_LDPC_SHIFT_CHECK_EN adds shift range checking with a sticky err flag.
module qc_ldpc_stream_encoder #(
  parameter int NUM_Z           = 3,
  parameter int Z_LIST [NUM_Z]  = '{27, 54, 81},
  parameter int MAX_Z           = 81,
  parameter int KB              = 20,
  parameter int MB              = 4,
  parameter int PLVL            = 1,
  parameter int SHIFT_W         = $clog2(MAX_Z) + 1
) (
  input  logic                            CLK,
  input  logic                            rst_n,
  input  logic [$clog2(NUM_Z)-1:0]        z_idx,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [MAX_Z*PLVL-1:0]           in_data,
  output logic [$clog2(KB/PLVL)-1:0]      rom_addr,
  input  logic [MB*PLVL*SHIFT_W-1:0]      rom_shift,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [MAX_Z-1:0]                out_data,
  output logic                            out_last,
  output logic                            err,
  output logic [1:0]                      dbg_state_o
);

  localparam int NGRP = KB / PLVL;
  localparam int GRP_W = $clog2(NGRP);
  localparam int ZI_W = $clog2(NUM_Z);
  localparam int P_W = $clog2(MB);
  localparam logic [SHIFT_W-1:0] NULL_S = '1;

  if ((KB % PLVL) != 0) begin : g_plvl_check
    $error("KB must be a multiple of PLVL");
  end

  // Handshakes: a beat transfers on a rising edge where valid and ready are both 1;
  // out_data/out_last stay stable while out_valid=1 and out_ready=0.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [GRP_W-1:0]  grp_q, grp_d;
  logic [P_W-1:0]    p_cnt_q, p_cnt_d;
  logic [ZI_W-1:0]   z_q, z_d;
  logic [MAX_Z-1:0]  acc_q [MB];
  logic [MAX_Z-1:0]  acc_d [MB];
  logic [MAX_Z-1:0]  acc_upd [MB];
  logic              live_q;
  logic              accept;
  logic [ZI_W-1:0]   cur_zi;
  int                z_cur;
`ifdef QC_LDPC_SHIFT_CHECK_EN
  logic              range_hit;
  logic              err_q;
`endif

  // Cyclic rotation within the low z bits: out[i] = b[(i+s) mod z], bits >= z cleared.
  function automatic logic [MAX_Z-1:0] rot(input logic [MAX_Z-1:0] b,
                                           input logic [SHIFT_W-1:0] s,
                                           input int z);
    logic [MAX_Z-1:0]   mask;
    logic [2*MAX_Z-1:0] w;
    for (int i = 0; i < MAX_Z; i++) mask[i] = (i < z);
    w = {{MAX_Z{1'b0}}, b & mask};
    w = (w << z) | w;
    w = w >> s;
    return w[MAX_Z-1:0] & mask;
  endfunction

  assign accept      = in_valid && in_ready;
  assign in_ready    = live_q && (state_q != S_DRAIN);
  assign out_valid   = (state_q == S_DRAIN);
  assign out_data    = out_valid ? acc_q[p_cnt_q] : '0;
  assign out_last    = out_valid && (p_cnt_q == P_W'(MB - 1));
  assign rom_addr    = grp_q;
  assign dbg_state_o = state_q;

  // The first beat of a frame uses z_idx directly; later beats use the latched value.
  always_comb begin
    cur_zi = (state_q == S_IDLE) ? z_idx : z_q;
    z_cur  = Z_LIST[NUM_Z-1];
    for (int i = 0; i < NUM_Z; i++) begin
      if (cur_zi == ZI_W'(i)) z_cur = Z_LIST[i];
    end
  end

  always_comb begin : p_datapath
    logic [SHIFT_W-1:0] s;
    logic               use_s;
    logic [MAX_Z-1:0]   x;
`ifdef QC_LDPC_SHIFT_CHECK_EN
    range_hit = 1'b0;
`endif
    for (int r = 0; r < MB; r++) begin
      x = (state_q == S_IDLE) ? '0 : acc_q[r];
      for (int k = 0; k < PLVL; k++) begin
        s     = rom_shift[(r*PLVL+k)*SHIFT_W +: SHIFT_W];
        use_s = (s != NULL_S);
`ifdef QC_LDPC_SHIFT_CHECK_EN
        if (use_s && (int'(s) >= z_cur)) begin
          use_s     = 1'b0;
          range_hit = 1'b1;
        end
`endif
        if (use_s) x = x ^ rot(in_data[k*MAX_Z +: MAX_Z], s, z_cur);
      end
      acc_upd[r] = x;
    end
  end

  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    p_cnt_d = p_cnt_q;
    z_d     = z_q;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE, S_ACCUM: begin
        if (accept) begin
          acc_d = acc_upd;
          if (state_q == S_IDLE) z_d = z_idx;
          if (grp_q == GRP_W'(NGRP - 1)) begin
            grp_d   = '0;
            state_d = S_DRAIN;
          end else begin
            grp_d   = grp_q + 1'b1;
            state_d = S_ACCUM;
          end
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (p_cnt_q == P_W'(MB - 1)) begin
            p_cnt_d = '0;
            state_d = S_IDLE;
          end else begin
            p_cnt_d = p_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grp_q   <= '0;
      p_cnt_q <= '0;
      z_q     <= '0;
      live_q  <= 1'b0;
      for (int r = 0; r < MB; r++) acc_q[r] <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      p_cnt_q <= p_cnt_d;
      z_q     <= z_d;
      live_q  <= 1'b1;
      for (int r = 0; r < MB; r++) acc_q[r] <= acc_d[r];
    end
  end

`ifdef QC_LDPC_SHIFT_CHECK_EN
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else if (accept && range_hit) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
